// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard and forwarding controller for the 5-stage core.
// A three-entry scoreboard (EX, MEM, WB) tracks in-flight destination registers.
// From it, and from the instruction in ID, the block drives the forward code,
// the forward source select, stall and flush.
// Optional macro HAZARD_STATS_EN adds the saturating stall_cnt/flush_cnt outputs.
module hazard_ctrl #(
  parameter int REG_AW   = 5,
  parameter int FWD_SRCS = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        id_valid,
  input  logic [6:0]                  id_opcode,
  input  logic [REG_AW-1:0]           id_rs1,
  input  logic [REG_AW-1:0]           id_rs2,
  input  logic [REG_AW-1:0]           id_rd,
  input  logic                        redirect,
  output logic [1:0]                  need_forward,
  output logic [$clog2(FWD_SRCS)-1:0] fwd_sel,
  output logic                        stall,
  output logic                        flush
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]                 stall_cnt,
  output logic [31:0]                 flush_cnt
`endif
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              wr_en;
    logic              is_load;
  } sb_entry_t;

  localparam logic [6:0] OP_ALU   = 7'b0110011;
  localparam logic [6:0] OP_ALUI  = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  sb_entry_t sb_ex, sb_mem, sb_wb;
  sb_entry_t id_entry;

  logic use_rs1, use_rs2, is_store;
  logic m1_ex, m1_mem, m2_ex, m2_mem;
  logic fwd1, fwd2;
  logic load_use, store_hz, conflict;
  logic issue;

  // A producer matches a source only if it really writes that non-zero register.
  function automatic logic hit(input sb_entry_t e, input logic [REG_AW-1:0] r);
    return e.valid && e.wr_en && (e.rd == r) && (r != '0);
  endfunction

  // Decode the ID instruction into scoreboard fields and operand usage.
  always_comb begin
    id_entry         = '0;
    id_entry.valid   = 1'b1;
    id_entry.rd      = id_rd;
    id_entry.wr_en   = (id_opcode inside {OP_ALU, OP_ALUI, OP_LOAD, OP_JAL,
                                          OP_JALR, OP_AUIPC, OP_LUI}) && (id_rd != '0);
    id_entry.is_load = (id_opcode == OP_LOAD);
    use_rs1          = !(id_opcode inside {OP_JAL, OP_AUIPC, OP_LUI});
    use_rs2          = id_opcode inside {OP_ALU, OP_BR, OP_STORE};
    is_store         = (id_opcode == OP_STORE);
  end

  // Hazard detection and forward selection; EX (youngest) wins over MEM.
  always_comb begin
    m1_ex    = use_rs1 && hit(sb_ex, id_rs1);
    m1_mem   = use_rs1 && !m1_ex && hit(sb_mem, id_rs1);
    m2_ex    = use_rs2 && hit(sb_ex, id_rs2);
    m2_mem   = use_rs2 && !m2_ex && hit(sb_mem, id_rs2);
    // store data is never forwarded; it waits until the producer is in WB
    fwd1     = m1_ex || m1_mem;
    fwd2     = !is_store && (m2_ex || m2_mem);
    load_use = sb_ex.is_load && (m1_ex || m2_ex);
    store_hz = is_store && (m2_ex || m2_mem);
    conflict = fwd1 && fwd2 && (m1_ex != m2_ex);

    flush = redirect && !reset;
    stall = id_valid && !flush && (load_use || store_hz || conflict);
    issue = id_valid && !stall && !flush;

    need_forward = 2'b00;
    fwd_sel      = '0;
    if (issue) begin
      need_forward = {fwd1, fwd2};
      fwd_sel[0]   = (fwd1 && m1_mem) || (fwd2 && m2_mem);
    end
  end

  // Scoreboard shift; a redirect kills the younger EX and MEM occupants.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sb_ex  <= '0;
      sb_mem <= '0;
      sb_wb  <= '0;
    end else begin
      sb_ex  <= issue ? id_entry : '0;
      sb_mem <= flush ? '0 : sb_ex;
      sb_wb  <= sb_mem;
    end
  end

`ifdef HAZARD_STATS_EN
  // Saturating event counters; stall is already low in flush cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != 32'hFFFF_FFFF)) stall_cnt <= stall_cnt + 32'd1;
      if (flush && (flush_cnt != 32'hFFFF_FFFF)) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and forwarding controller for the 5-stage core (IF/ID/EX/MEM/WB).
- Tracks in-flight destination registers for EX, MEM and WB in a small internal scoreboard.
- Drives the ALU's need_forward code and selects the single forward source.
- Issues stalls for load-use, store-data and forward-conflict hazards, and flushes on redirect from a resolved branch or jump.

Parameters:
- REG_AW, 5, register index width.
- FWD_SRCS, 2, number of forward sources (EX/MEM result, MEM/WB result); fixed at 2.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-high reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_opcode  in  7  opcode of the ID instruction.
- id_rs1  in  REG_AW  source 1 index.
- id_rs2  in  REG_AW  source 2 index.
- id_rd  in  REG_AW  destination index.
- redirect  in  1  branch/jump resolved taken; the instruction is in MEM; valid one cycle.
- need_forward  out  2  to ALU; bit1 = forward rs1, bit0 = forward rs2.
- fwd_sel  out  1  0 = EX/MEM result, 1 = MEM/WB result.
- stall  out  1  hold PC and IF/ID; a bubble enters EX.
- flush  out  1  kill IF/ID and ID/EX contents.

Behaviour:
- Scoreboard: three entries (EX, MEM, WB); each holds valid, rd, wr_en, is_load. Advances every clock edge.
- Entry input to EX:
  - ID contents when id_valid & !stall & !flush.
  - Otherwise a bubble (valid=0).
- Decode rules:
  - wr_en = 1 for opcodes 0110011, 0010011, 0000011, 1101111, 1100111, 0010111, 0110111, and only when rd != 0.
  - is_load = 1 for 0000011.
  - rs1 is used by all opcodes except 1101111, 0010111, 0110111.
  - rs2 is used by 0110011, 1100011 (ALU) and 0100011 (store data).
- Match: a source matches a stage when the entry is valid, wr_en = 1, rd equals the source, and the source != 0. Register x0 never forwards and never stalls.
- Priority: EX entry over MEM entry (youngest producer wins). The WB stage never forwards; the register file is write-through.
- Load-use: a used source matches a load in EX -> stall = 1 for exactly 1 cycle.
- Store data (opcode 0100011, rs2): matches EX or MEM -> stall until the producer reaches WB. rs1 forwards normally.
- ALU sources:
  - Required source for each operand: EX -> fwd_sel 0; MEM -> fwd_sel 1.
  - Both operands forwarded from the same stage -> need_forward = 11.
  - Operands need different stages -> stall 1 cycle. The conflict then resolves because the older producer reaches WB.
- need_forward and fwd_sel are 0 whenever stall, flush or !id_valid.
- Flush: redirect = 1 -> flush = 1 in the same cycle (combinational). On the next edge, EX and MEM entries become bubbles. flush overrides stall.
- Outputs are combinational from the scoreboard and ID inputs; scoreboard update latency is 1 cycle.
- Reset (async, any time including mid-stall): all entries invalid. stall = 0, flush = 0, need_forward = 00, fwd_sel = 0 while reset is held and after release until new state arrives.

Optional Feature:
- Macro HAZARD_STATS_EN. When defined, adds these outputs:
  - stall_cnt  out  32: cycles with stall = 1, excluding flush cycles.
  - flush_cnt  out  32: flush events.
- Both counters clear on reset, saturate at 0xFFFFFFFF and do not wrap.
- When not defined, the ports and counters are absent and the remaining behaviour is identical.

Test Plan:
- add x5,x1,x2 then add x6,x5,x3: second in ID, first in EX -> need_forward=10, fwd_sel=0, stall=0.
- lw x5,0(x1) then add x6,x5,x5 -> cycle 1: stall=1, need_forward=00; cycle 2: need_forward=11, fwd_sel=1.
- add x5,..; add x7,..; sub x8,x7,x5 (x7 in EX, x5 in MEM) -> stall=1 for 1 cycle; then need_forward=10, fwd_sel=1.
- addi x0,x0,1 then add x3,x0,x0 -> need_forward=00, stall=0.
- Load producer in EX while redirect=1 -> flush=1, stall=0. Next cycle EX/MEM entries invalid; no forwarding from killed instructions.
- Assert reset mid-stall, release -> stall=0, need_forward=00. With HAZARD_STATS_EN defined: stall_cnt=0 and flush_cnt=0 after reset.
